// File: rtl/ro_freq_counter.sv
// ro_freq_counter: gated ring-oscillator edge counter (clk, rst_n active-high async, start, ro_in -> ro_activate, busy, done, count, overflow)
module ro_freq_counter #(
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_in,
  output logic             ro_activate,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);
  localparam int PH_MAX = GATE_CYCLES > SETTLE_CYCLES ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;
  state_t           state, state_nx;
  logic             s1, s2, s3, pulse, sat, ovf, ovf_nx, settle_end, gate_end;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] edges, edges_nx;
  assign pulse      = s2 & ~s3;
  assign sat        = &edges;
  assign settle_end = phase == PH_W'(SETTLE_CYCLES - 1);
  assign gate_end   = phase == PH_W'(GATE_CYCLES - 1);
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  always_comb begin
    edges_nx = edges + CNT_W'(pulse & ~sat);
    ovf_nx   = ovf | (pulse & sat);
    state_nx = state == IDLE   ? (start ? SETTLE : IDLE) :
               state == SETTLE ? (settle_end ? COUNT : SETTLE) :
               state == COUNT  ? (gate_end ? DONE : COUNT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) state <= IDLE;
    else       state <= state_nx;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      phase       <= '0;
      edges       <= '0;
      ovf         <= 1'b0;
      ro_activate <= 1'b0;
      count       <= '0;
      overflow    <= 1'b0;
    end else begin
      s1 <= ro_in;
      s2 <= s1;
      s3 <= s2;
      if (state == IDLE && start) begin
        phase       <= '0;
        edges       <= '0;
        ovf         <= 1'b0;
        ro_activate <= 1'b1;
      end
      if (state == SETTLE) phase <= settle_end ? '0 : phase + PH_W'(1);
      if (state == COUNT) begin
        phase <= phase + PH_W'(1);
        edges <= edges_nx;
        ovf   <= ovf_nx;
        if (gate_end) begin
          ro_activate <= 1'b0;
          count       <= edges_nx;
          overflow    <= ovf_nx;
        end
      end
    end
endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: directed and randomized checks of ro_freq_counter against an edge-history model
module tb_ro_freq_counter;
  localparam int S  = 4;
  localparam int GA = 64;
  localparam int GB = 128;
  logic        clk = 0, rst_n = 1, ro_in = 0, start_a = 0, start_b = 0;
  logic        act_a, busy_a, done_a, ovf_a, act_b, busy_b, done_b, ovf_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  int          checks = 0, failures = 0, cyc = 0, per = 0, ph = 0, prev_a = 0, prev_b = 0, got;
  bit          lvl = 0;
  bit          hist [0:16383];
  ro_freq_counter #(.GATE_CYCLES(GA), .SETTLE_CYCLES(S), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .ro_in(ro_in), .ro_activate(act_a),
    .busy(busy_a), .done(done_a), .count(cnt_a), .overflow(ovf_a));
  ro_freq_counter #(.GATE_CYCLES(GB), .SETTLE_CYCLES(S), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .ro_in(ro_in), .ro_activate(act_b),
    .busy(busy_b), .done(done_b), .count(cnt_b), .overflow(ovf_b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    ro_in = per == 0 ? lvl : (((cyc + ph) % per) < per / 2);
    hist[cyc] = ro_in;
  endtask
  // Rising edges of ro_in whose conditioned pulse lands in one of the gate cycles
  task automatic model(input int t0, input int g, input int w, output int c, output int o);
    int r = 0;
    int mx = (1 << w) - 1;
    for (int k = t0 + S + 1; k <= t0 + S + g; k++) r += int'(hist[k-2] && !hist[k-3]);
    c = r > mx ? mx : r;
    o = int'(r > mx);
  endtask
  task automatic measure(input bit b, input bit inj, input string tag, output int res);
    int g = b ? GB : GA;
    int w = b ? 4 : 16;
    int t0, ec, eo, prev;
    int done_at = -1, nd = 0, act = 0, bz = 0, hold_bad = 0;
    prev = b ? prev_b : prev_a;
    t0 = cyc;
    chk({tag, "_idle"}, int'(b ? busy_b : busy_a), 0);
    if (b) start_b = 1; else start_a = 1;
    for (int k = 1; k <= S + g + 2; k++) begin
      tick();
      start_a = 0;
      start_b = 0;
      if (inj && (k == 2 || k == S + 10 || k == S + g + 1)) begin
        if (b) start_b = 1; else start_a = 1;
      end
      if (b ? done_b : done_a) begin
        nd++;
        if (done_at < 0) done_at = k;
      end
      if (b ? act_b : act_a) act++;
      if (b ? busy_b : busy_a) bz++;
      if (k <= S + g && (b ? int'(cnt_b) : int'(cnt_a)) != prev) hold_bad++;
    end
    start_a = 0;
    start_b = 0;
    model(t0, g, w, ec, eo);
    res = b ? int'(cnt_b) : int'(cnt_a);
    chk({tag, "_done_lat"}, done_at, S + g + 1);
    chk({tag, "_done_n"}, nd, 1);
    chk({tag, "_act_cyc"}, act, S + g);
    chk({tag, "_busy_cyc"}, bz, S + g + 1);
    chk({tag, "_hold"}, hold_bad, 0);
    chk({tag, "_count"}, res, ec);
    chk({tag, "_ovf"}, int'(b ? ovf_b : ovf_a), eo);
    chk({tag, "_end_idle"}, int'(b ? busy_b : busy_a), 0);
    if (b) prev_b = ec; else prev_a = ec;
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_act_a", int'(act_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    chk("rst_ovf_a", int'(ovf_a), 0);
    chk("rst_act_b", int'(act_b), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_cnt_b", int'(cnt_b), 0);
    rst_n = 0;
    repeat (2) tick();
    per = 8; ph = $urandom_range(0, 7);
    repeat (5) tick();
    measure(0, 0, "t1", got);
    chk("t1_range", int'(got >= 7 && got <= 9), 1);
    per = 0; lvl = 0;
    repeat (5) tick();
    measure(0, 0, "t2_lo", got);
    chk("t2_lo_zero", got, 0);
    lvl = 1;
    repeat (5) tick();
    measure(0, 0, "t2_hi", got);
    chk("t2_hi_zero", got, 0);
    per = 4; ph = $urandom_range(0, 3);
    measure(1, 0, "t3_sat", got);
    chk("t3_sat15", got, 15);
    chk("t3_ovf1", int'(ovf_b), 1);
    per = 0; lvl = 0;
    repeat (5) tick();
    measure(1, 0, "t3_static", got);
    chk("t3_ovf0", int'(ovf_b), 0);
    per = 8; ph = $urandom_range(0, 7);
    measure(0, 1, "t4", got);
    start_a = 1;
    tick();
    start_a = 0;
    repeat (S + 20) tick();
    rst_n = 1;
    #1;
    chk("t5_act", int'(act_a), 0);
    chk("t5_busy", int'(busy_a), 0);
    chk("t5_cnt", int'(cnt_a), 0);
    chk("t5_ovf", int'(ovf_a), 0);
    chk("t5_done", int'(done_a), 0);
    repeat (2) tick();
    rst_n = 0;
    prev_a = 0; prev_b = 0;
    tick();
    measure(0, 0, "t5_after", got);
    per = 8; ph = $urandom_range(0, 7);
    measure(0, 0, "t6_r1", got);
    chk("t6_r1_range", int'(got >= 7 && got <= 9), 1);
    per = 16;
    measure(0, 0, "t6_r2", got);
    chk("t6_r2_range", int'(got >= 3 && got <= 5), 1);
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        per = 0; lvl = 1'($urandom_range(0, 1));
      end else begin
        per = 2 * $urandom_range(2, 10); ph = $urandom_range(0, per - 1);
      end
      measure(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), got);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
